arbitro_rr_param: RTL and testbench

//  Parametrised arbiter between N_CH input FIFOs and N_CH output FIFOs.

---
 rtl/arbitro_rr_param_pkg.sv | 12 +
 rtl/arbitro_rr_param_if.sv | 24 ++
 rtl/arbitro_rr_param_pick.sv | 33 +++
 rtl/arbitro_rr_param.sv | 117 +++++++++++
 tb/tb_arbitro_rr_param.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/arbitro_rr_param_pkg.sv
// Shared types and constants for the round-robin / fixed-priority FIFO arbiter.
package arbitro_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

endpackage

// File: rtl/arbitro_rr_param_if.sv
// FIFO-side bundle of the arbiter: input FIFO status, output FIFO status and controls.
interface arbitro_rr_param_if #(
    parameter int N_CH = 4
);
    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0] emptyFIFO;
    logic [N_CH-1:0] almost_fullFIFO;
    logic [N_CH-1:0] pop;
    logic [N_CH-1:0] push;
    logic [GW-1:0]   grant_idx;
    logic            active;
    logic            stall;

    modport master (
        input  emptyFIFO, almost_fullFIFO,
        output pop, push, grant_idx, active, stall
    );

    modport slave (
        output emptyFIFO, almost_fullFIFO,
        input  pop, push, grant_idx, active, stall
    );
endinterface

// File: rtl/arbitro_rr_param_pick.sv
// Combinational channel picker: lowest requester, or first requester at/after rr_ptr.
module arb_pick
    import arbitro_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int MODE = MODE_RR,
    localparam int GW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [GW-1:0]   rr_ptr_i,
    output logic [GW-1:0]   g_o,
    output logic            valid_o
);

    always_comb begin
        int   idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        g_o     = '0;
        valid_o = 1'b0;
        // Scan from the start point with wrap; the first hit wins.
        for (int k = 0; k < N_CH; k++) begin
            idx = (MODE == MODE_RR) ? ((int'(rr_ptr_i) + k) % N_CH) : k;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                g_o   = GW'(idx);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/arbitro_rr_param.sv
// Arbiter between N_CH input FIFOs and N_CH output FIFOs with bursty grants
// and a pop-to-push delay line matching the input FIFO read latency.
module arbitro_rr_param
    import arbitro_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int BURST    = 2,
    parameter int MODE     = MODE_RR,
    parameter int PIPE_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    arbitro_rr_param_if.master       bus
);

    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [N_CH-1:0] pipe_q [PIPE_LAT];

    logic [N_CH-1:0] req;
    logic [N_CH-1:0] pop_c;
    logic [GW-1:0]   pick_g;
    logic            pick_valid;
    logic            stall_c;
    logic            popping;

    assign req     = ~bus.emptyFIFO;
    assign stall_c = |bus.almost_fullFIFO;

    arb_pick #(
        .N_CH (N_CH),
        .MODE (MODE)
    ) u_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .g_o      (pick_g),
        .valid_o  (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
        end
    end

    // A stall freezes the grant entirely, including the drained-queue exit.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        case (state_q)
            ARB: begin
                if (pick_valid && !stall_c) begin
                    state_d = GRANT;
                    grant_d = pick_g;
                    burst_d = '0;
                end
            end
            GRANT: begin
                if (!stall_c) begin
                    if (popping) begin
                        burst_d = burst_q + 1'b1;
                    end
                    if ((popping && burst_q == BW'(BURST - 1)) || bus.emptyFIFO[grant_q]) begin
                        state_d  = ARB;
                        burst_d  = '0;
                        rr_ptr_d = (grant_q == GW'(N_CH - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        pop_c = '0;
        if (state_q == GRANT && !reset && !bus.emptyFIFO[grant_q] && !stall_c) begin
            pop_c[grant_q] = 1'b1;
        end
    end

    assign popping = |pop_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= pop_c;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign bus.pop       = pop_c;
    assign bus.push      = reset ? '0 : pipe_q[PIPE_LAT-1];
    assign bus.grant_idx = grant_q;
    assign bus.active    = (state_q == GRANT) && !reset;
    assign bus.stall     = stall_c;

endmodule

// File: tb/tb_arbitro_rr_param.sv
// Directed bench: one round-robin and one fixed-priority arbiter, N_CH=4, BURST=2, PIPE_LAT=1.
module tb_arbitro_rr_param;
    import arbitro_pkg::*;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] emptyV = 4'hF;
    logic [3:0] afV    = 4'h0;
    int         total  = 0;
    int         bad    = 0;

    always #5 clk = ~clk;

    arbitro_rr_param_if #(.N_CH(4)) bus1 ();
    arbitro_rr_param_if #(.N_CH(4)) bus0 ();

    assign bus1.emptyFIFO       = emptyV;
    assign bus1.almost_fullFIFO = afV;
    assign bus0.emptyFIFO       = emptyV;
    assign bus0.almost_fullFIFO = afV;

    arbitro_rr_param #(.N_CH(4), .BURST(2), .MODE(MODE_RR), .PIPE_LAT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    arbitro_rr_param #(.N_CH(4), .BURST(2), .MODE(MODE_FIXED), .PIPE_LAT(1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] e, input logic [3:0] a);
        reset  = r;
        emptyV = e;
        afV    = a;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expectRr(input string tag, input logic act, input logic [1:0] g,
                            input logic [3:0] p, input logic [3:0] ps);
        checkOutput({tag, ".active"}, 32'(bus1.active), 32'(act));
        checkOutput({tag, ".pop"},    32'(bus1.pop),    32'(p));
        checkOutput({tag, ".push"},   32'(bus1.push),   32'(ps));
        if (act) checkOutput({tag, ".grant"}, 32'(bus1.grant_idx), 32'(g));
    endtask

    task automatic expectFixed(input string tag, input logic act, input logic [3:0] p);
        checkOutput({tag, ".active0"}, 32'(bus0.active), 32'(act));
        checkOutput({tag, ".pop0"},    32'(bus0.pop),    32'(p));
        if (act) checkOutput({tag, ".grant0"}, 32'(bus0.grant_idx), 32'd0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 4'hF, 4'h0);
        nextCycle();
        nextCycle();
    endtask

    initial begin
        int         seq [5];
        logic [3:0] prevPop;
        logic [3:0] p;
        seq = '{0, 1, 2, 3, 0};

        @(posedge clk);
        #1;

        // Reset held with every queue empty.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'hF, 4'h0);
            expectRr("rst", 1'b0, 2'd0, 4'h0, 4'h0);
            expectFixed("rst", 1'b0, 4'h0);
            nextCycle();
        end
        applyStimulus(1'b0, 4'hF, 4'h0);
        expectRr("idle0", 1'b0, 2'd0, 4'h0, 4'h0);
        nextCycle();
        expectRr("idle1", 1'b0, 2'd0, 4'h0, 4'h0);
        checkOutput("idle.stall", 32'(bus1.stall), 32'd0);

        // Channel 0 empty: round-robin starts at 1, then moves to 2.
        doReset();
        applyStimulus(1'b0, 4'b0001, 4'h0);
        expectRr("t2.arb", 1'b0, 2'd0, 4'h0, 4'h0);
        nextCycle();
        expectRr("t2.g1a", 1'b1, 2'd1, 4'b0010, 4'h0);
        nextCycle();
        expectRr("t2.g1b", 1'b1, 2'd1, 4'b0010, 4'b0010);
        nextCycle();
        expectRr("t2.arb2", 1'b0, 2'd0, 4'h0, 4'b0010);
        nextCycle();
        expectRr("t2.g2", 1'b1, 2'd2, 4'b0100, 4'h0);

        // All channels requesting: 0,1,2,3,0 with one bubble between grants.
        doReset();
        applyStimulus(1'b0, 4'b0000, 4'h0);
        prevPop = 4'h0;
        for (int k = 0; k < 5; k++) begin
            p = 4'b0001 << seq[k];
            expectRr("t3.arb", 1'b0, 2'd0, 4'h0, prevPop);
            nextCycle();
            expectRr("t3.pa", 1'b1, 2'(seq[k]), p, 4'h0);
            nextCycle();
            expectRr("t3.pb", 1'b1, 2'(seq[k]), p, p);
            prevPop = p;
            nextCycle();
        end

        // Fixed priority keeps returning to channel 0.
        doReset();
        applyStimulus(1'b0, 4'b0000, 4'h0);
        for (int r = 0; r < 2; r++) begin
            expectFixed("t4.arb", 1'b0, 4'h0);
            nextCycle();
            expectFixed("t4.pa", 1'b1, 4'b0001);
            nextCycle();
            expectFixed("t4.pb", 1'b1, 4'b0001);
            nextCycle();
        end
        expectFixed("t4.end", 1'b0, 4'h0);

        // Stall mid-burst: the in-flight push drains, then the burst finishes.
        doReset();
        applyStimulus(1'b0, 4'b0000, 4'h0);
        expectRr("t5.arb", 1'b0, 2'd0, 4'h0, 4'h0);
        nextCycle();
        expectRr("t5.p1", 1'b1, 2'd0, 4'b0001, 4'h0);
        nextCycle();
        applyStimulus(1'b0, 4'b0000, 4'b1000);
        expectRr("t5.st1", 1'b1, 2'd0, 4'h0, 4'b0001);
        checkOutput("t5.stall1", 32'(bus1.stall), 32'd1);
        nextCycle();
        expectRr("t5.st2", 1'b1, 2'd0, 4'h0, 4'h0);
        nextCycle();
        applyStimulus(1'b0, 4'b0000, 4'h0);
        expectRr("t5.p2", 1'b1, 2'd0, 4'b0001, 4'h0);
        checkOutput("t5.stall0", 32'(bus1.stall), 32'd0);
        nextCycle();
        expectRr("t5.arb2", 1'b0, 2'd0, 4'h0, 4'b0001);
        nextCycle();
        expectRr("t5.g1", 1'b1, 2'd1, 4'b0010, 4'h0);

        // Reset mid-burst drops the pending push and rewinds the pointer.
        doReset();
        applyStimulus(1'b0, 4'b0000, 4'h0);
        nextCycle();
        nextCycle();
        nextCycle();
        expectRr("t6.arb", 1'b0, 2'd0, 4'h0, 4'b0001);
        nextCycle();
        expectRr("t6.g1", 1'b1, 2'd1, 4'b0010, 4'h0);
        nextCycle();
        applyStimulus(1'b1, 4'b0000, 4'h0);
        expectRr("t6.rst", 1'b0, 2'd0, 4'h0, 4'h0);
        nextCycle();
        applyStimulus(1'b0, 4'b0000, 4'h0);
        expectRr("t6.post", 1'b0, 2'd0, 4'h0, 4'h0);
        nextCycle();
        expectRr("t6.g0", 1'b1, 2'd0, 4'b0001, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
